// File: rtl/ddr_clkmux_sel_ctrl_if.sv
// Request/status bundle between the clock-select requester and the mux select sequencer.
interface ddr_clkmux_sel_ctrl_if;
    localparam int unsigned SEL_W = 2;

    logic             i_req_vld;
    logic [SEL_W-1:0] i_req_sel;
    logic             o_req_rdy;
    logic [SEL_W-1:0] o_sel;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_req_vld, i_req_sel,
        input  o_req_rdy, o_sel, o_busy, o_done
    );

    modport slave (
        input  i_req_vld, i_req_sel,
        output o_req_rdy, o_sel, o_busy, o_done
    );
endinterface

// File: rtl/ddr_clkmux_sel_ctrl.sv
// Glitch-free select sequencer for the 3:1 clock mux: park at 00, apply the new
// source, settle, then pulse done. Never switches directly between two sources.
module ddr_clkmux_sel_ctrl #(
    parameter int unsigned GATE_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CNT_WIDTH     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ddr_clkmux_sel_ctrl_if.slave bus
);
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_WIDTH) - 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATE   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    // Reject interval settings the shared counter cannot represent.
    if (GATE_CYCLES < 1 || GATE_CYCLES > CNT_MAX) begin : g_bad_gate
        $error("GATE_CYCLES out of range for CNT_WIDTH");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > CNT_MAX) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range for CNT_WIDTH");
    end

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0]     tgt_q,   tgt_d;
    logic [SEL_W-1:0]     sel_q,   sel_d;
    logic                 rdy_q,   rdy_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            sel_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_vld && rdy_q) begin
                    tgt_d = bus.i_req_sel;
                    // Re-selecting the current code completes without touching the mux.
                    if (bus.i_req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_GATE;
                        sel_d   = '0;
                        rdy_d   = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_WIDTH'(GATE_CYCLES - 1);
                    end
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    if (tgt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        rdy_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_SETTLE;
                        sel_d   = tgt_q;
                        cnt_d   = CNT_WIDTH'(SETTLE_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.o_sel     = sel_q;
    assign bus.o_req_rdy = rdy_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;

    // A live source may only ever be followed by itself or by park.
    sel_no_direct_swap: assert property (@(posedge i_clk) disable iff (i_rst)
        ($past(sel_q) != 2'b00 && sel_q != 2'b00) |-> (sel_q == $past(sel_q)));
endmodule

// File: tb/tb_ddr_clkmux_sel_ctrl.sv
// Directed bench for ddr_clkmux_sel_ctrl with G=4, S=8.
module tb_ddr_clkmux_sel_ctrl;
    localparam int unsigned G = 4;
    localparam int unsigned S = 8;
    localparam int unsigned N_SRC  = G + S + 1;
    localparam int unsigned N_PARK = G + 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [1:0] prev_sel;

    ddr_clkmux_sel_ctrl_if bus ();

    ddr_clkmux_sel_ctrl #(
        .GATE_CYCLES  (G),
        .SETTLE_CYCLES(S),
        .CNT_WIDTH    (4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge; afterwards we sit in cycle 1.
    task automatic issue(input logic [1:0] req);
        bus.i_req_vld = 1'b1;
        bus.i_req_sel = req;
        step();
        bus.i_req_vld = 1'b0;
        bus.i_req_sel = ~req;
    endtask

    // Walk cycles first..last of a sequence toward tgt, ending in the done cycle.
    task automatic expect_seq(input string tag, input logic [1:0] tgt,
                              input int first, input int last);
        for (int c = first; c <= last; c++) begin
            chk({tag, "_sel"},  32'(bus.o_sel),     (c <= int'(G)) ? 32'd0 : 32'(tgt));
            chk({tag, "_done"}, 32'(bus.o_done),    32'(c == last));
            chk({tag, "_rdy"},  32'(bus.o_req_rdy), 32'(c == last));
            chk({tag, "_busy"}, 32'(bus.o_busy),    32'(c != last));
            if (c < last) step();
        end
    endtask

    // Independent watch for a direct source-to-source change on the select.
    always @(negedge clk) begin
        if (!rst)
            chk("no_direct_swap",
                32'(prev_sel != 2'b00 && bus.o_sel != 2'b00 && bus.o_sel != prev_sel), 32'd0);
        prev_sel = bus.o_sel;
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        prev_sel = 2'b00;
        rst = 1'b1;
        bus.i_req_vld = 1'b0;
        bus.i_req_sel = 2'b00;

        step();
        step();
        rst = 1'b0;
        chk("rst_sel",  32'(bus.o_sel),     32'd0);
        chk("rst_rdy",  32'(bus.o_req_rdy), 32'd1);
        chk("rst_busy", 32'(bus.o_busy),    32'd0);
        chk("rst_done", 32'(bus.o_done),    32'd0);
        step();

        // Select 01 from park.
        issue(2'b01);
        expect_seq("park_to_01", 2'b01, 1, N_SRC);
        step();
        chk("post01_done", 32'(bus.o_done), 32'd0);
        chk("post01_sel",  32'(bus.o_sel),  32'd1);

        // Swap 01 -> 11 through park.
        issue(2'b11);
        expect_seq("swap_11", 2'b11, 1, N_SRC);
        step();

        // Reach 10, then same-source request, then park.
        issue(2'b10);
        expect_seq("swap_10", 2'b10, 1, N_SRC);
        step();
        issue(2'b10);
        chk("same_done", 32'(bus.o_done),    32'd1);
        chk("same_sel",  32'(bus.o_sel),     32'd2);
        chk("same_busy", 32'(bus.o_busy),    32'd0);
        chk("same_rdy",  32'(bus.o_req_rdy), 32'd1);
        step();
        chk("same_done_drop", 32'(bus.o_done), 32'd0);
        issue(2'b00);
        expect_seq("park", 2'b00, 1, N_PARK);
        step();
        chk("park_idle_sel", 32'(bus.o_sel), 32'd0);

        // Backpressure: second request held through the first sequence.
        bus.i_req_vld = 1'b1;
        bus.i_req_sel = 2'b01;
        step();
        bus.i_req_sel = 2'b11;
        expect_seq("bp_first", 2'b01, 1, N_SRC);
        step();
        bus.i_req_vld = 1'b0;
        bus.i_req_sel = 2'b00;
        expect_seq("bp_second", 2'b11, 1, N_SRC);
        step();

        // Park, then reset in cycle 6 of a 00 -> 10 sequence.
        issue(2'b00);
        expect_seq("park2", 2'b00, 1, N_PARK);
        step();
        issue(2'b10);
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_sel", 32'(bus.o_sel), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_sel",  32'(bus.o_sel),     32'd0);
        chk("midrst_busy", 32'(bus.o_busy),    32'd0);
        chk("midrst_rdy",  32'(bus.o_req_rdy), 32'd1);
        chk("midrst_done", 32'(bus.o_done),    32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("midrst_no_done", 32'(bus.o_done), 32'd0);
            chk("midrst_hold_sel", 32'(bus.o_sel), 32'd0);
        end

        // Normal operation resumes after the dropped request.
        issue(2'b10);
        expect_seq("after_rst", 2'b10, 1, N_SRC);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
